// File: rtl/muxn_pipe.sv
`default_nettype none
// ============================================================================
// Module      : muxn_pipe
// Description : Registered N-to-1 data multiplexer with a valid/ready
//               handshake on both sides. The selected word is captured at
//               acceptance into a two-entry buffer (main + skid), so every
//               output and in_ready come straight from flops, and the block
//               sustains one beat per cycle when downstream is always ready.
//               A select value >= N produces an all-zero word flagged by
//               out_err.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH     data width of each input and of the output (default 32)
//   N         number of data inputs, 2..16 (default 4)
//   SELW      select width, $clog2(N) (derived)
// Ports
//   clk       single clock, rising edge
//   reset_n   asynchronous active-low reset
//   in_data   flattened inputs, input k at [k*WIDTH +: WIDTH]
//   sel       input index, qualified by in_valid
//   in_valid  upstream offers in_data/sel
//   in_ready  block can accept this cycle (registered)
//   out_data  selected word (registered)
//   out_err   sel of this beat was >= N (registered)
//   out_valid out_data/out_err valid (registered)
//   out_ready downstream accepts
//   err_cnt   saturating count of out-of-range selects
// Configuration
//   MUXN_PIPE_ERRCNT_EN  when defined, err_cnt counts accepted out-of-range
//                        beats (saturating at 255); otherwise err_cnt is 0
//                        and no counter is built.
// ============================================================================
module muxn_pipe #(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_err,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         err_cnt
);

  // N expressed one bit wider than sel so the range compare cannot wrap.
  localparam logic [SELW:0] c_n_lim = (SELW + 1)'(N);

  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_err;
  logic             w_accept;
  logic             w_deliver;
  logic             w_skid_valid_nxt;

  logic             r_main_valid;
  logic [WIDTH-1:0] r_main_data;
  logic             r_main_err;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_skid_err;
  logic             r_in_ready;

  // Indices >= N match no input, leaving the word at zero for error beats.
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (sel == SELW'(k)) begin
        w_sel_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_sel_err = ({1'b0, sel} >= c_n_lim);
  assign w_accept  = in_valid && r_in_ready;
  assign w_deliver = r_main_valid && out_ready;

  // in_ready is only high while skid is empty, so an accepted beat never
  // meets a full skid. Skid ends up occupied only when main stays full and
  // either already held the skid beat or takes a new one.
  assign w_skid_valid_nxt = w_deliver ? 1'b0
                                      : (r_skid_valid || (w_accept && r_main_valid));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_main_err   <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_err   <= 1'b0;
      r_in_ready   <= 1'b0;
    end else begin
      if (w_deliver) begin
        if (r_skid_valid) begin
          // Skid beat is older than anything arriving now: promote it.
          r_main_data  <= r_skid_data;
          r_main_err   <= r_skid_err;
          r_skid_valid <= 1'b0;
        end else if (w_accept) begin
          r_main_data  <= w_sel_data;
          r_main_err   <= w_sel_err;
        end else begin
          r_main_valid <= 1'b0;
        end
      end else if (w_accept) begin
        if (!r_main_valid) begin
          r_main_valid <= 1'b1;
          r_main_data  <= w_sel_data;
          r_main_err   <= w_sel_err;
        end else begin
          r_skid_valid <= 1'b1;
          r_skid_data  <= w_sel_data;
          r_skid_err   <= w_sel_err;
        end
      end
      r_in_ready <= !w_skid_valid_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;
  assign out_err   = r_main_err;

`ifdef MUXN_PIPE_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_cnt <= 8'h00;
    end else if (w_accept && w_sel_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = 8'h00;
`endif

endmodule
`default_nettype wire
